uart_tx_arbiter: RTL and testbench

//  Shares the UART transmit path (TX FIFO write port: wr_en/d_in/tx_full) among NUM_REQ byte-stream requesters.

---
 rtl/uart_tx_arbiter_if.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte-stream requesters, the TX arbiter
// and the UART TX FIFO write port.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 fifo_wr_en;
  logic [7:0]           fifo_din;
  logic                 fifo_full;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    output fifo_full,
    input  req_ready,
    input  fifo_wr_en,
    input  fifo_din,
    input  grant,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  fifo_full,
    output req_ready,
    output fifo_wr_en,
    output fifo_din,
    output grant,
    output busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Burst-granular round-robin arbiter sharing the UART TX FIFO write port.
// Define UART_ARB_TAG_EN to prefix each grant with a {4'hA, id} header byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd2;
`ifdef UART_ARB_TAG_EN
  localparam logic [1:0] S_TAG   = 2'd1;
`endif

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [7:0]         cnt_q, cnt_d;

  logic               sel_found;
  logic [IW-1:0]      sel_idx;
  logic               own_valid;
  logic               own_last;
  logic [7:0]         own_data;
  logic               xfer;
  logic               burst_end;
  logic [IW-1:0]      nxt_ptr;
`ifdef UART_ARB_TAG_EN
  logic [3:0]         tag_id;
`endif

  // First valid requester at or after rr_q, wrapping modulo NUM_REQ.
  always_comb begin
    int k;
    logic [IW-1:0] kk;
    sel_found = 1'b0;
    sel_idx   = '0;
    k         = 0;
    kk        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(rr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      kk = IW'(k);
      if (!sel_found && bus.req_valid[kk]) begin
        sel_found = 1'b1;
        sel_idx   = kk;
      end
    end
  end

  assign own_valid = bus.req_valid[gidx_q];
  assign own_last  = bus.req_last[gidx_q];
  assign own_data  = bus.req_data[{gidx_q, 3'b000} +: 8];
  assign nxt_ptr   = (int'(gidx_q) == NUM_REQ - 1) ? '0 : gidx_q + 1'b1;
`ifdef UART_ARB_TAG_EN
  assign tag_id    = 4'(gidx_q);
`endif

  always_comb begin
    bus.req_ready  = '0;
    bus.fifo_wr_en = 1'b0;
    bus.fifo_din   = 8'h00;
    xfer           = 1'b0;
    case (state_q)
      S_BURST: begin
        bus.req_ready  = grant_q & {NUM_REQ{~bus.fifo_full}};
        xfer           = own_valid & ~bus.fifo_full;
        bus.fifo_wr_en = xfer;
        bus.fifo_din   = xfer ? own_data : 8'h00;
      end
`ifdef UART_ARB_TAG_EN
      S_TAG: begin
        bus.fifo_wr_en = ~bus.fifo_full;
        bus.fifo_din   = bus.fifo_full ? 8'h00 : {4'hA, tag_id};
      end
`endif
      default: begin
        bus.req_ready  = '0;
      end
    endcase
  end

  // Tag byte is not a data byte, so it never touches cnt_q.
  assign burst_end = xfer &
                     (own_last | (cnt_q == 8'(MAX_BURST - 1)));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          grant_d = NUM_REQ'(1) << sel_idx;
          gidx_d  = sel_idx;
          cnt_d   = 8'd0;
`ifdef UART_ARB_TAG_EN
          state_d = S_TAG;
`else
          state_d = S_BURST;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      S_TAG: begin
        if (!bus.fifo_full) state_d = S_BURST;
      end
`endif
      S_BURST: begin
        if (burst_end) begin
          state_d = S_IDLE;
          grant_d = '0;
          gidx_d  = '0;
          cnt_d   = 8'd0;
          rr_d    = nxt_ptr;
        end else if (xfer) begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        gidx_d  = '0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = (state_q != S_IDLE);

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    bus.fifo_full |-> !bus.fifo_wr_en);

  a_grant_onehot: assert property (
    @(posedge clk) disable iff (reset)
    $onehot0(grant_q));

  a_ready_owner: assert property (
    @(posedge clk) disable iff (reset)
    (bus.req_ready & ~grant_q) == '0);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=4).
// Expected FIFO byte stream is queued per scenario and popped on writes.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;
`ifdef UART_ARB_TAG_EN
  localparam int TAGC = 1;
`else
  localparam int TAGC = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ  (N),
    .MAX_BURST(MB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [8:0] src_q [N][$];
  logic [7:0] exp_q [$];
  logic [N-1:0] ghist [$];
  int cyc;
  int full_from;
  int full_len;
  int wr_count;
  int first_wr_cyc;
  int last_wr_cyc;
  logic [7:0] first_wr;

  task automatic push_tag(input int id);
    if (TAGC == 1) exp_q.push_back(8'hA0 | 8'(id));
  endtask

  task automatic load(input int i, input logic [7:0] b,
                      input logic l);
    src_q[i].push_back({l, b});
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    ghist.delete();
  endtask

  task automatic start();
    cyc = 0;
    wr_count = 0;
    full_from = 0;
    full_len = 0;
    first_wr_cyc = -1;
    last_wr_cyc = -1;
    first_wr = 8'h00;
    ghist.delete();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++)
      if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() != 0) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_data[8*i +: 8] = src_q[i][0][7:0];
        bus.req_last[i]        = src_q[i][0][8];
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_data[8*i +: 8] = 8'h00;
        bus.req_last[i]        = 1'b0;
      end
    end
    bus.fifo_full = (full_len > 0) && (cyc >= full_from) &&
                    (cyc < full_from + full_len);
  endtask

  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    drive_inputs();
    #1;
    total++;
    if ((bus.req_ready & ~bus.grant) !== '0) begin
      bad++;
      $display("FAIL ready_nongrant cyc=%0d ready=%b grant=%b",
               cyc, bus.req_ready, bus.grant);
    end
    if (bus.fifo_full) begin
      total++;
      if (bus.fifo_wr_en !== 1'b0 || bus.req_ready !== '0) begin
        bad++;
        $display("FAIL stall cyc=%0d wr_en=%b ready=%b want 0",
                 cyc, bus.fifo_wr_en, bus.req_ready);
      end
    end
    if (bus.fifo_wr_en === 1'b1) begin
      if (wr_count == 0) begin
        first_wr = bus.fifo_din;
        first_wr_cyc = cyc;
      end
      last_wr_cyc = cyc;
      wr_count++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write cyc=%0d din=%h", cyc,
                 bus.fifo_din);
      end else begin
        e = exp_q.pop_front();
        if (bus.fifo_din !== e) begin
          bad++;
          $display("FAIL fifo_din cyc=%0d got=%h want=%h", cyc,
                   bus.fifo_din, e);
        end
      end
    end
    if (ghist.size() == 0 || ghist[ghist.size()-1] !== bus.grant)
      ghist.push_back(bus.grant);
    for (int i = 0; i < N; i++)
      if (bus.req_valid[i] && bus.req_ready[i])
        void'(src_q[i].pop_front());
    cyc++;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    forever begin
      step();
      n++;
      if (all_empty() && exp_q.size() == 0 && bus.busy === 1'b0)
        break;
      if (n >= budget) begin
        total++;
        bad++;
        $display("FAIL %s timeout after %0d cycles left=%0d",
                 name, n, exp_q.size());
        break;
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s missing_writes got=%0d want=0", name,
               exp_q.size());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if (bus.grant !== '0 || bus.busy !== 1'b0 ||
        bus.fifo_wr_en !== 1'b0 || bus.fifo_din !== 8'h00 ||
        bus.req_ready !== '0) begin
      bad++;
      $display("FAIL %s grant=%b busy=%b wr=%b din=%h rdy=%b want 0",
               name, bus.grant, bus.busy, bus.fifo_wr_en,
               bus.fifo_din, bus.req_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    check_idle_outputs("reset_state");
  endtask

  task automatic test_single();
    start();
    load(0, 8'h11, 1'b0);
    load(0, 8'h22, 1'b0);
    load(0, 8'h33, 1'b1);
    push_tag(0);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    drain("single", 30);
    total++;
    if (wr_count != 3 + TAGC) begin
      bad++;
      $display("FAIL single_count got=%0d want=%0d", wr_count,
               3 + TAGC);
    end
    total++;
    if (first_wr_cyc != 1) begin
      bad++;
      $display("FAIL single_latency got=%0d want=1", first_wr_cyc);
    end
    total++;
    if (last_wr_cyc != 3 + TAGC) begin
      bad++;
      $display("FAIL single_consecutive got=%0d want=%0d",
               last_wr_cyc, 3 + TAGC);
    end
  endtask

  task automatic test_rr_ptr();
    start();
    load(0, 8'h40, 1'b1);
    load(1, 8'h41, 1'b1);
    push_tag(1);
    exp_q.push_back(8'h41);
    push_tag(0);
    exp_q.push_back(8'h40);
    drain("rr_ptr", 30);
  endtask

  task automatic test_contention();
    logic [N-1:0] want [5];
    want[0] = 4'b0000;
    want[1] = 4'b0001;
    want[2] = 4'b0000;
    want[3] = 4'b0100;
    want[4] = 4'b0000;
    do_reset();
    start();
    load(0, 8'h01, 1'b0);
    load(0, 8'h02, 1'b1);
    load(2, 8'h21, 1'b0);
    load(2, 8'h22, 1'b1);
    push_tag(0);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    push_tag(2);
    exp_q.push_back(8'h21);
    exp_q.push_back(8'h22);
    drain("contention", 40);
    total++;
    if (ghist.size() != 5) begin
      bad++;
      $display("FAIL grant_seq_len got=%0d want=5", ghist.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (ghist[i] !== want[i]) begin
          bad++;
          $display("FAIL grant_seq[%0d] got=%b want=%b", i,
                   ghist[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_burst_cap();
    do_reset();
    start();
    for (int b = 0; b < 10; b++)
      load(1, 8'h50 + 8'(b), (b == 9));
    load(3, 8'h70, 1'b0);
    load(3, 8'h71, 1'b1);
    push_tag(1);
    for (int b = 0; b < 4; b++) exp_q.push_back(8'h50 + 8'(b));
    push_tag(3);
    exp_q.push_back(8'h70);
    exp_q.push_back(8'h71);
    push_tag(1);
    for (int b = 4; b < 8; b++) exp_q.push_back(8'h50 + 8'(b));
    push_tag(1);
    exp_q.push_back(8'h58);
    exp_q.push_back(8'h59);
    drain("burst_cap", 80);
    total++;
    if (wr_count != 12 + 4 * TAGC) begin
      bad++;
      $display("FAIL burst_cap_count got=%0d want=%0d", wr_count,
               12 + 4 * TAGC);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    start();
    for (int b = 0; b < 4; b++)
      load(2, 8'h60 + 8'(b), (b == 3));
    push_tag(2);
    for (int b = 0; b < 4; b++) exp_q.push_back(8'h60 + 8'(b));
    full_from = 3 + TAGC;
    full_len  = 5;
    drain("backpressure", 40);
    total++;
    if (wr_count != 4 + TAGC) begin
      bad++;
      $display("FAIL bp_count got=%0d want=%0d", wr_count, 4 + TAGC);
    end
    total++;
    if (last_wr_cyc != 9 + TAGC) begin
      bad++;
      $display("FAIL bp_resume got=%0d want=%0d", last_wr_cyc,
               9 + TAGC);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    start();
    for (int b = 0; b < 5; b++)
      load(0, 8'h80 + 8'(b), (b == 4));
    push_tag(0);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h81);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (exp_q.size() != 0 || bus.fifo_wr_en !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_write left=%0d wr=%b want 0/1",
               exp_q.size(), bus.fifo_wr_en);
    end
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    clear_all();
    drive_inputs();
    @(negedge clk);
    reset = 1'b0;
    start();
    load(1, 8'h91, 1'b1);
    load(0, 8'h90, 1'b1);
    push_tag(0);
    exp_q.push_back(8'h90);
    push_tag(1);
    exp_q.push_back(8'h91);
    drain("after_reset", 30);
  endtask

  task automatic test_tag();
    logic [7:0] want;
    start();
    want = (TAGC == 1) ? 8'hA2 : 8'hC1;
    load(2, 8'hC1, 1'b0);
    load(2, 8'hC2, 1'b1);
    push_tag(2);
    exp_q.push_back(8'hC1);
    exp_q.push_back(8'hC2);
    drain("tag", 30);
    total++;
    if (first_wr !== want) begin
      bad++;
      $display("FAIL tag_first got=%h want=%h", first_wr, want);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_ptr();
    test_contention();
    test_burst_cap();
    test_backpressure();
    test_reset_mid();
    test_tag();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
